// File: rtl/bitserial_nn_wload_ctrl_if.sv
// ============================================================================
// bitserial_nn_wload_ctrl_if : weight stream in, engine weight-write port out
// Revision 1.0
// ============================================================================
`default_nettype none

interface bitserial_nn_wload_ctrl_if #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 12,
    parameter int N_HIDDEN = 6,
    parameter int N_LAYERS = 3
);
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int HW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam int IW = (N_IN > 1)     ? $clog2(N_IN)     : 1;

    logic [DATA_W-1:0] s_wt_tdata;
    logic              s_wt_tvalid;
    logic              s_wt_tready;
    logic              s_wt_tlast;

    logic              w_wr_en;
    logic [LW-1:0]     w_addr_l;
    logic [HW-1:0]     w_addr_h;
    logic [IW-1:0]     w_addr_i;
    logic [DATA_W-1:0] w_data;

    modport slave (
        input  s_wt_tdata, s_wt_tvalid, s_wt_tlast,
        output s_wt_tready,
        output w_wr_en, w_addr_l, w_addr_h, w_addr_i, w_data
    );

    modport master (
        output s_wt_tdata, s_wt_tvalid, s_wt_tlast,
        input  s_wt_tready,
        input  w_wr_en, w_addr_l, w_addr_h, w_addr_i, w_data
    );
endinterface

`default_nettype wire

// File: rtl/bitserial_nn_wload_ctrl.sv
// ============================================================================
// bitserial_nn_wload_ctrl : streams weights into bitserial_nn, gates inference
// Revision 1.0
// ============================================================================
`default_nettype none

module bitserial_nn_wload_ctrl #(
    parameter int  DATA_W   = 16,
    parameter int  N_IN     = 12,
    parameter int  N_HIDDEN = 6,
    parameter int  N_LAYERS = 3,
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
    localparam int HW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1,
    localparam int IW = (N_IN > 1)     ? $clog2(N_IN)     : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          cfg_single,
    input  logic [LW-1:0] cfg_layer,
    input  logic          nn_busy,
    bitserial_nn_wload_ctrl_if.slave wt,
    output logic          infer_enable,
    output logic          ctrl_busy,
    output logic          load_done,
    output logic          load_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_NN = 2'd1,
        S_LOAD    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          weights_valid, wv_nxt;
    logic          done_nxt, err_nxt, start_ok;
    logic          single_q;
    logic [LW-1:0] l_q;
    logic [HW-1:0] h_q;
    logic [IW-1:0] i_q;

    logic hs, load_hs, last_i, last_h, last_l, final_beat, bad_layer;

    assign wt.s_wt_tready = (state == S_LOAD) || (state == S_DRAIN);
    assign ctrl_busy      = (state != S_IDLE);

    assign hs         = wt.s_wt_tvalid && wt.s_wt_tready;
    assign load_hs    = hs && (state == S_LOAD);
    assign last_i     = (i_q == IW'(N_IN - 1));
    assign last_h     = (h_q == HW'(N_HIDDEN - 1));
    assign last_l     = single_q || (l_q == LW'(N_LAYERS - 1));
    assign final_beat = last_i && last_h && last_l;
    assign bad_layer  = cfg_single && ({1'b0, cfg_layer} >= (LW + 1)'(N_LAYERS));

    always_comb begin
        state_nxt = state;
        wv_nxt    = weights_valid;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        start_ok  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    if (bad_layer) begin
                        err_nxt = 1'b1;
                    end else begin
                        start_ok  = 1'b1;
                        wv_nxt    = 1'b0;
                        state_nxt = nn_busy ? S_WAIT_NN : S_LOAD;
                    end
                end
            end
            S_WAIT_NN: begin
                if (!nn_busy) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (hs) begin
                    if (final_beat) begin
                        if (wt.s_wt_tlast) begin
                            done_nxt  = 1'b1;
                            wv_nxt    = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            // Set is complete but the stream is not; swallow the remainder
                            err_nxt   = 1'b1;
                            state_nxt = S_DRAIN;
                        end
                    end else if (wt.s_wt_tlast) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (hs && wt.s_wt_tlast) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            weights_valid <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            infer_enable  <= 1'b0;
        end else begin
            state         <= state_nxt;
            weights_valid <= wv_nxt;
            load_done     <= done_nxt;
            load_err      <= err_nxt;
            infer_enable  <= wv_nxt && (state_nxt == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            single_q <= 1'b0;
            l_q      <= '0;
            h_q      <= '0;
            i_q      <= '0;
        end else if (start_ok) begin
            single_q <= cfg_single;
            l_q      <= cfg_single ? cfg_layer : '0;
            h_q      <= '0;
            i_q      <= '0;
        end else if (load_hs) begin
            if (last_i) begin
                i_q <= '0;
                if (last_h) begin
                    h_q <= '0;
                    l_q <= l_q + 1'b1;
                end else begin
                    h_q <= h_q + 1'b1;
                end
            end else begin
                i_q <= i_q + 1'b1;
            end
        end
    end

    // Write port: address/data hold between strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wt.w_wr_en  <= 1'b0;
            wt.w_addr_l <= '0;
            wt.w_addr_h <= '0;
            wt.w_addr_i <= '0;
            wt.w_data   <= '0;
        end else begin
            wt.w_wr_en <= load_hs;
            if (load_hs) begin
                wt.w_addr_l <= l_q;
                wt.w_addr_h <= h_q;
                wt.w_addr_i <= i_q;
                wt.w_data   <= DATA_W'(wt.s_wt_tdata);
            end
        end
    end

endmodule

`default_nettype wire
